// File: rtl/pipelined_carry_skip_adder.sv
// Carry-skip adder/subtractor with one skip block per pipeline stage and a
// valid/ready stream interface; the whole pipe freezes while the output is stalled.
module pipelined_carry_skip_adder #(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NBLK = WIDTH / BLOCK;

   // Returns {carry_out, sum_bits} of a BLOCK-bit ripple chain.
   function automatic logic [BLOCK:0] ripple_blk(input logic [BLOCK-1:0] x,
                                                 input logic [BLOCK-1:0] y,
                                                 input logic             ci);
      logic [BLOCK-1:0] s;
      logic             c;
      s = '0;
      c = ci;
      for (int i = 0; i < BLOCK; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      return {c, s};
   endfunction

   function automatic logic skip_mux(input logic [BLOCK-1:0] x,
                                     input logic [BLOCK-1:0] y,
                                     input logic             ci,
                                     input logic             rc);
      return (&(x ^ y)) ? ci : rc;
   endfunction

   logic             stall;
   logic [WIDTH-1:0] b_eff;
   logic             c0;
   logic             out_valid_d, out_valid_q;
   logic [WIDTH-1:0] res_sum_d, res_sum_q;
   logic             cout_d, cout_q;
   logic             ovf_d, ovf_q;

   always_comb begin
      stall = out_valid_q & ~out_ready;
      b_eff = sub ? ~b : b;
      c0    = cin ^ sub;
   end

   assign in_ready  = ~stall;
   assign out_valid = out_valid_q;
   assign sum       = res_sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

   // Stages 0..NBLK-2: each carries only the operand bits still to be summed.
   for (genvar k = 0; k < NBLK - 1; k++) begin : stg
      localparam int IN_W = WIDTH - k * BLOCK;
      localparam int RW   = IN_W - BLOCK;
      localparam int SW   = (k + 1) * BLOCK;

      logic [IN_W-1:0] a_in, b_in;
      logic            c_in, vld_in;
      logic [BLOCK:0]  rip;
      logic [SW-1:0]   sum_d, sum_q;
      logic [RW-1:0]   a_d, a_q, b_d, b_q;
      logic            c_d, c_q, vld_d, vld_q;

      if (k == 0) begin : g_src
         assign a_in   = a;
         assign b_in   = b_eff;
         assign c_in   = c0;
         assign vld_in = in_valid;
         always_comb sum_d = rip[BLOCK-1:0];
      end else begin : g_src
         assign a_in   = stg[k-1].a_q;
         assign b_in   = stg[k-1].b_q;
         assign c_in   = stg[k-1].c_q;
         assign vld_in = stg[k-1].vld_q;
         always_comb sum_d = {rip[BLOCK-1:0], stg[k-1].sum_q};
      end

      always_comb begin
         rip   = ripple_blk(a_in[BLOCK-1:0], b_in[BLOCK-1:0], c_in);
         c_d   = skip_mux(a_in[BLOCK-1:0], b_in[BLOCK-1:0], c_in, rip[BLOCK]);
         a_d   = a_in[IN_W-1:BLOCK];
         b_d   = b_in[IN_W-1:BLOCK];
         vld_d = vld_in;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= 1'b0;
         end else if (!stall) begin
            vld_q <= vld_d;
         end
      end

      always_ff @(posedge clk) begin
         if (!stall) begin
            sum_q <= sum_d;
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
         end
      end
   end

   // Final stage: top block, carry out and overflow into the output register.
   logic [BLOCK-1:0] a_l, b_l;
   logic             c_l, vld_l;
   logic [BLOCK:0]   rip_l;

   if (NBLK == 1) begin : g_last
      assign a_l   = a;
      assign b_l   = b_eff;
      assign c_l   = c0;
      assign vld_l = in_valid;
      always_comb res_sum_d = rip_l[BLOCK-1:0];
   end else begin : g_last
      assign a_l   = stg[NBLK-2].a_q;
      assign b_l   = stg[NBLK-2].b_q;
      assign c_l   = stg[NBLK-2].c_q;
      assign vld_l = stg[NBLK-2].vld_q;
      always_comb res_sum_d = {rip_l[BLOCK-1:0], stg[NBLK-2].sum_q};
   end

   always_comb begin
      rip_l       = ripple_blk(a_l, b_l, c_l);
      cout_d      = skip_mux(a_l, b_l, c_l, rip_l[BLOCK]);
      // carry into the MSB is recovered as a ^ b ^ sum at that bit
      ovf_d       = (a_l[BLOCK-1] ^ b_l[BLOCK-1] ^ rip_l[BLOCK-1]) ^ cout_d;
      out_valid_d = vld_l;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         res_sum_q   <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else if (!stall) begin
         out_valid_q <= out_valid_d;
         if (out_valid_d) begin
            res_sum_q <= res_sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Directed and randomised bench for the 16-bit, 4-block pipelined carry-skip adder.
module tb_pipelined_carry_skip_adder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   int n_checks = 0;
   int n_fail   = 0;

   pipelined_carry_skip_adder #(.WIDTH(16), .BLOCK(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural reference: {sum, cout, ovf}
   function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                         input logic mc, input logic ms);
      logic [15:0] bb;
      logic [16:0] full;
      logic        cm;
      bb   = ms ? ~mb : mb;
      full = {1'b0, ma} + {1'b0, bb} + {16'h0000, mc ^ ms};
      cm   = ma[15] ^ bb[15] ^ full[15];
      return {full[15:0], full[16], cm ^ full[16]};
   endfunction

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 7))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h8000;
         3:       return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                         input logic ts, output logic [17:0] res, output int lat);
      a = ta; b = tbv; cin = tc; sub = ts;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      res = {sum, cout, ovf};
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      n_checks++;
      if ({out_valid, sum, cout, ovf} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected %h", {out_valid, sum, cout, ovf}, 19'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_add();
      logic [17:0] r;
      int          lat;
      drain();
      run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, r, lat);
      n_checks++;
      if (lat !== 4) begin
         n_fail++; $display("FAIL add_latency: got %0d expected 4", lat);
      end
      n_checks++;
      if (r !== {16'h0100, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL add_00ff_0001: got %h expected %h", r, {16'h0100, 1'b0, 1'b0});
      end
      run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, r, lat);
      n_checks++;
      if (r !== {16'h0000, 1'b1, 1'b0} || lat !== 4) begin
         n_fail++;
         $display("FAIL add_full_skip: got %h lat %0d expected %h lat 4", r, lat, {16'h0000, 1'b1, 1'b0});
      end
   endtask

   task automatic test_sub_ovf();
      logic [17:0] r;
      int          lat;
      drain();
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1, r, lat);
      n_checks++;
      if (r !== {16'hFFFE, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL sub_5_7: got %h expected %h", r, {16'hFFFE, 1'b0, 1'b0});
      end
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, r, lat);
      n_checks++;
      if (r !== {16'h7FFF, 1'b1, 1'b1}) begin
         n_fail++; $display("FAIL sub_ovf: got %h expected %h", r, {16'h7FFF, 1'b1, 1'b1});
      end
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, r, lat);
      n_checks++;
      if (r !== {16'h8000, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL add_ovf: got %h expected %h", r, {16'h8000, 1'b0, 1'b1});
      end
      run_op(16'h1234, 16'h0034, 1'b1, 1'b1, r, lat);
      n_checks++;
      if (r !== {16'h11FF, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL sub_borrow_in: got %h expected %h", r, {16'h11FF, 1'b1, 1'b0});
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] opa [6];
      logic [15:0] opb [6];
      logic        ops [6];
      logic [17:0] expv [6];
      logic [17:0] hold_val;
      logic        held, saw_stall, acc;
      int          sent, rcv, cyc;
      opa  = '{16'h0001, 16'hFFFF, 16'h1234, 16'h0010, 16'h0000, 16'h8000};
      opb  = '{16'h0002, 16'h0001, 16'h4321, 16'h0010, 16'h0001, 16'h8000};
      ops  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      expv = '{{16'h0003, 1'b0, 1'b0}, {16'h0000, 1'b1, 1'b0}, {16'h5555, 1'b0, 1'b0},
               {16'h0000, 1'b1, 1'b0}, {16'hFFFF, 1'b0, 1'b0}, {16'h0000, 1'b1, 1'b1}};
      drain();
      sent = 0; rcv = 0; cyc = 0; held = 1'b0; saw_stall = 1'b0; hold_val = '0;
      while (rcv < 6 && cyc < 60) begin
         out_ready = !(cyc >= 5 && cyc <= 7);
         in_valid  = (sent < 6);
         if (sent < 6) begin
            a = opa[sent]; b = opb[sent]; cin = 1'b0; sub = ops[sent];
         end
         #1;
         if (held) begin
            n_checks++;
            if ({out_valid, sum, cout, ovf} !== {1'b1, hold_val}) begin
               n_fail++;
               $display("FAIL b2b_hold: got %h expected %h", {out_valid, sum, cout, ovf}, {1'b1, hold_val});
            end
         end
         if (out_valid && !out_ready) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
               n_fail++; $display("FAIL b2b_in_ready_stall: got %b expected 0", in_ready);
            end
            held = 1'b1; saw_stall = 1'b1; hold_val = {sum, cout, ovf};
         end else begin
            held = 1'b0;
         end
         if (out_valid && out_ready) begin
            n_checks++;
            if ({sum, cout, ovf} !== expv[rcv]) begin
               n_fail++;
               $display("FAIL b2b_result_%0d: got %h expected %h", rcv, {sum, cout, ovf}, expv[rcv]);
            end
            rcv++;
         end
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) sent++;
         cyc++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (rcv != 6 || !saw_stall) begin
         n_fail++; $display("FAIL b2b_complete: got %0d results stall=%b expected 6 stall=1", rcv, saw_stall);
      end
   endtask

   task automatic test_reset_flush();
      logic [17:0] r;
      int          lat;
      drain();
      for (int i = 0; i < 3; i++) begin
         a = 16'(i + 1); b = 16'h0100; cin = 1'b0; sub = 1'b0;
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_valid_%0d: got %b expected 0", i, out_valid);
         end
         @(posedge clk); #1;
      end
      run_op(16'h1111, 16'h2222, 1'b1, 1'b0, r, lat);
      n_checks++;
      if (lat !== 4 || r !== {16'h3334, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL flush_next_op: got %h lat %0d expected %h lat 4", r, lat, {16'h3334, 1'b0, 1'b0});
      end
   endtask

   task automatic test_random();
      logic [17:0] expq [$];
      logic [17:0] e;
      logic        pend, acc;
      int          sent, rcv, cyc;
      drain();
      sent = 0; rcv = 0; cyc = 0; pend = 1'b0;
      while ((sent < 2000 || rcv < sent) && cyc < 20000) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if (!pend) begin
            if (sent < 2000 && $urandom_range(0, 9) < 7) begin
               a = pick(); b = pick();
               cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
               in_valid = 1'b1; pend = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
         end
         #1;
         if (out_valid && out_ready) begin
            n_checks++;
            if (expq.size() == 0) begin
               n_fail++; $display("FAIL rand_spurious: got %h expected no result", {sum, cout, ovf});
            end else begin
               e = expq.pop_front();
               if ({sum, cout, ovf} !== e) begin
                  n_fail++; $display("FAIL rand_result_%0d: got %h expected %h", rcv, {sum, cout, ovf}, e);
               end
            end
            rcv++;
         end
         acc = in_valid && in_ready;
         if (acc) begin
            expq.push_back(model(a, b, cin, sub));
            sent++;
         end
         @(posedge clk); #1;
         if (acc) begin
            pend = 1'b0; in_valid = 1'b0;
         end
         cyc++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (sent != 2000 || rcv != 2000) begin
         n_fail++; $display("FAIL rand_complete: got sent %0d received %0d expected 2000/2000", sent, rcv);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_ovf();
      test_back_to_back();
      test_reset_flush();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
